// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, default frame parameters
// and the parity helper used by both directions.
package uart_pkg;

  localparam int unsigned DEF_BAUD_DIV   = 16;
  localparam int unsigned DEF_DATA_BITS  = 8;
  localparam int unsigned DEF_PARITY_EN  = 1;
  localparam int unsigned DEF_PARITY_ODD = 0;
  localparam int unsigned DEF_STOP_BITS  = 1;
  localparam int unsigned TIMER_W        = 16;

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP
  } rx_state_t;

  // Payloads narrower than 8 bits are zero-extended, which leaves the XOR unchanged.
  function automatic logic parity_bit(input logic [7:0] data, input logic odd);
    return odd ? ~(^data) : ^data;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Loadable down-counter; expire_c is high in the last cycle of a loaded period,
// so a load of N produces expiry N clock edges after the load.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int unsigned W = TIMER_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expire_c
);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign expire_c = (count == W'(1));

endmodule

// File: rtl/uart_if.sv
// Full-duplex UART: independent TX and RX state machines, each paced by its
// own bit timer; RX input is double-synchronized before any use.
module uart_if
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_DIV   = DEF_BAUD_DIV,
  parameter int unsigned DATA_BITS  = DEF_DATA_BITS,
  parameter int unsigned PARITY_EN  = DEF_PARITY_EN,
  parameter int unsigned PARITY_ODD = DEF_PARITY_ODD,
  parameter int unsigned STOP_BITS  = DEF_STOP_BITS
) (
  input  logic                 pclk,
  input  logic                 areset,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err
);

  localparam int unsigned        IDX_W     = 3;
  localparam logic [IDX_W-1:0]   LAST_BIT  = IDX_W'(DATA_BITS - 1);
  localparam logic [TIMER_W-1:0] FULL_BIT  = TIMER_W'(BAUD_DIV);
  localparam logic [TIMER_W-1:0] HALF_BIT  = TIMER_W'(BAUD_DIV / 2);
  localparam logic               LAST_STOP = 1'(STOP_BITS - 1);
  localparam logic               PAR_ODD   = 1'(PARITY_ODD);

  // ---------------- transmitter ----------------
  tx_state_t            tx_state;
  logic [DATA_BITS-1:0] tx_shift;
  logic                 tx_par;
  logic [IDX_W-1:0]     tx_idx;
  logic                 tx_stop_idx;
  logic                 tx_load;
  logic                 tx_expire;

  assign tx_load = (tx_state == TX_IDLE) ? tx_valid : tx_expire;

  uart_bit_timer #(.W(TIMER_W)) u_tx_timer (
    .clk      (pclk),
    .rst      (areset),
    .load     (tx_load),
    .load_val (FULL_BIT),
    .expire_c (tx_expire)
  );

  always_ff @(posedge pclk or posedge areset) begin
    if (areset) begin
      tx_state    <= TX_IDLE;
      tx          <= 1'b1;
      tx_ready    <= 1'b1;
      tx_shift    <= '0;
      tx_par      <= 1'b0;
      tx_idx      <= '0;
      tx_stop_idx <= 1'b0;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (tx_valid) begin
            tx_shift <= tx_data;
            tx_par   <= parity_bit(8'(tx_data), PAR_ODD);
            tx       <= 1'b0;
            tx_ready <= 1'b0;
            tx_state <= TX_START;
          end
        end
        TX_START: begin
          if (tx_expire) begin
            tx       <= tx_shift[0];
            tx_shift <= tx_shift >> 1;
            tx_idx   <= '0;
            tx_state <= TX_DATA;
          end
        end
        TX_DATA: begin
          if (tx_expire) begin
            if (tx_idx == LAST_BIT) begin
              if (PARITY_EN != 0) begin
                tx       <= tx_par;
                tx_state <= TX_PARITY;
              end else begin
                tx          <= 1'b1;
                tx_stop_idx <= 1'b0;
                tx_state    <= TX_STOP;
              end
            end else begin
              tx       <= tx_shift[0];
              tx_shift <= tx_shift >> 1;
              tx_idx   <= tx_idx + IDX_W'(1);
            end
          end
        end
        TX_PARITY: begin
          if (tx_expire) begin
            tx          <= 1'b1;
            tx_stop_idx <= 1'b0;
            tx_state    <= TX_STOP;
          end
        end
        TX_STOP: begin
          if (tx_expire) begin
            if (tx_stop_idx == LAST_STOP) begin
              tx_ready <= 1'b1;
              tx_state <= TX_IDLE;
            end else begin
              tx_stop_idx <= 1'b1;
            end
          end
        end
        default: begin
          tx       <= 1'b1;
          tx_ready <= 1'b1;
          tx_state <= TX_IDLE;
        end
      endcase
    end
  end

  // ---------------- receiver ----------------
  rx_state_t            rx_state;
  logic                 rx_meta;
  logic                 rx_sync;
  logic                 rx_prev;
  logic                 rx_fall;
  logic [DATA_BITS-1:0] rx_shift;
  logic [IDX_W-1:0]     rx_idx;
  logic                 rx_par_bit;
  logic                 rx_load;
  logic [TIMER_W-1:0]   rx_load_val;
  logic                 rx_expire;

  // rx_prev makes IDLE wait for a true high-to-low edge, so a line left low
  // after a framing error cannot re-trigger until it has gone high again.
  always_ff @(posedge pclk or posedge areset) begin
    if (areset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign rx_fall     = rx_prev & ~rx_sync;
  assign rx_load     = (rx_state == RX_IDLE) ? rx_fall : rx_expire;
  assign rx_load_val = (rx_state == RX_IDLE) ? HALF_BIT : FULL_BIT;

  uart_bit_timer #(.W(TIMER_W)) u_rx_timer (
    .clk      (pclk),
    .rst      (areset),
    .load     (rx_load),
    .load_val (rx_load_val),
    .expire_c (rx_expire)
  );

  always_ff @(posedge pclk or posedge areset) begin
    if (areset) begin
      rx_state      <= RX_IDLE;
      rx_shift      <= '0;
      rx_idx        <= '0;
      rx_par_bit    <= 1'b0;
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (rx_fall) begin
            rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (rx_expire) begin
            if (rx_sync) begin
              rx_state <= RX_IDLE;
            end else begin
              rx_idx   <= '0;
              rx_state <= RX_DATA;
            end
          end
        end
        RX_DATA: begin
          if (rx_expire) begin
            rx_shift <= {rx_sync, rx_shift[DATA_BITS-1:1]};
            if (rx_idx == LAST_BIT) begin
              rx_state <= (PARITY_EN != 0) ? RX_PARITY : RX_STOP;
            end else begin
              rx_idx <= rx_idx + IDX_W'(1);
            end
          end
        end
        RX_PARITY: begin
          if (rx_expire) begin
            rx_par_bit <= rx_sync;
            rx_state   <= RX_STOP;
          end
        end
        RX_STOP: begin
          if (rx_expire) begin
            rx_data       <= rx_shift;
            rx_valid      <= 1'b1;
            rx_frame_err  <= ~rx_sync;
            rx_parity_err <= (PARITY_EN != 0) &&
                             (rx_par_bit != parity_bit(8'(rx_shift), PAR_ODD));
            rx_state      <= RX_IDLE;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_if.sv
// Randomized bench for uart_if (default parameters): frames are built from the
// frame rules, TX is compared per cycle and RX results are collected in a queue.
module tb_uart_if;

  localparam int BAUD = 16;

  logic       pclk = 1'b0;
  logic       areset;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx;
  logic       rx_line;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_parity_err;
  logic       rx_frame_err;

  logic       loopback;
  logic       rx_drv;
  logic [9:0] rxq[$];
  logic [7:0] last_rx;
  int         errors = 0;
  int         checks = 0;

  assign rx_line = loopback ? tx : rx_drv;

  uart_if dut (
    .pclk          (pclk),
    .areset        (areset),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .tx            (tx),
    .rx            (rx_line),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_parity_err (rx_parity_err),
    .rx_frame_err  (rx_frame_err)
  );

  always #5 pclk = ~pclk;

  // Every received frame is logged; a pulse longer than one cycle shows up twice.
  always @(negedge pclk) begin
    if (rx_valid === 1'b1) rxq.push_back({rx_frame_err, rx_parity_err, rx_data});
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Line levels of one frame, index = bit slot: start, 8 data LSB first, even parity, stop.
  function automatic logic [10:0] frame_bits(input logic [7:0] d, input logic pflip,
                                             input logic stopv);
    logic [10:0] f;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = d[i];
    f[9]  = (^d) ^ pflip;
    f[10] = stopv;
    return f;
  endfunction

  // Called just after a negedge with the transmitter idle; returns one negedge
  // after the frame ends, so consecutive calls are back-to-back.
  task automatic send_tx(input logic [7:0] d, input logic noise);
    logic [10:0] f;
    f = frame_bits(d, 1'b0, 1'b1);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge pclk);
    tx_valid = 1'b0;
    for (int k = 0; k < 11 * BAUD; k++) begin
      check("tx_bit", tx, f[k / BAUD]);
      check("tx_ready_low", tx_ready, 1'b0);
      tx_valid = (noise && k < 11 * BAUD - 1) ? 1'($urandom) : 1'b0;
      tx_data  = 8'($urandom);
      @(negedge pclk);
    end
    tx_valid = 1'b0;
    check("tx_ready_back", tx_ready, 1'b1);
    check("tx_idle", tx, 1'b1);
  endtask

  task automatic drive_rx(input logic [7:0] d, input logic pflip, input logic stopv,
                          input logic hold_low);
    logic [10:0] f;
    f = frame_bits(d, pflip, stopv);
    for (int b = 0; b < 11; b++) begin
      rx_drv = f[b];
      repeat (BAUD) @(negedge pclk);
    end
    if (hold_low) begin
      rx_drv = 1'b0;
      repeat (3 * BAUD) @(negedge pclk);
      check("ferr_no_rearm", 32'(rxq.size()), 1);
    end
    rx_drv = 1'b1;
    repeat (2 * BAUD) @(negedge pclk);
  endtask

  task automatic check_rx(input logic [7:0] d, input logic pe, input logic fe);
    logic [9:0] e;
    check("rx_count", 32'(rxq.size()), 1);
    if (rxq.size() > 0) begin
      e = rxq.pop_front();
      check("rx_data", e[7:0], d);
      check("rx_parity_err", e[8], pe);
      check("rx_frame_err", e[9], fe);
    end
    rxq.delete();
    last_rx = d;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    logic       pf;
    logic       st;

    areset   = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    loopback = 1'b1;
    rx_drv   = 1'b1;
    last_rx  = 8'h00;
    #3;
    check("rst_tx", tx, 1'b1);
    check("rst_tx_ready", tx_ready, 1'b1);
    check("rst_rx_valid", rx_valid, 1'b0);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_rx_perr", rx_parity_err, 1'b0);
    check("rst_rx_ferr", rx_frame_err, 1'b0);
    @(negedge pclk);
    areset = 1'b0;

    // Accepted on the first edge after release; looped back into RX.
    send_tx(8'hA5, 1'b0);
    check_rx(8'hA5, 1'b0, 1'b0);
    send_tx(8'h3C, 1'b0);
    check_rx(8'h3C, 1'b0, 1'b0);
    repeat (4) begin
      d = 8'($urandom);
      send_tx(d, 1'b1);
      check_rx(d, 1'b0, 1'b0);
    end

    loopback = 1'b0;
    repeat (4) @(negedge pclk);
    drive_rx(8'h01, 1'b1, 1'b1, 1'b0);
    check_rx(8'h01, 1'b1, 1'b0);
    drive_rx(8'hFF, 1'b0, 1'b0, 1'b1);
    check_rx(8'hFF, 1'b0, 1'b1);

    // Short low glitch must be rejected, leaving RX ready for a real frame.
    rx_drv = 1'b0;
    repeat (4) @(negedge pclk);
    rx_drv = 1'b1;
    repeat (3 * BAUD) @(negedge pclk);
    check("glitch_no_valid", 32'(rxq.size()), 0);
    check("glitch_hold_data", rx_data, last_rx);
    d = 8'($urandom);
    drive_rx(d, 1'b0, 1'b1, 1'b0);
    check_rx(d, 1'b0, 1'b0);

    repeat (5) begin
      d  = 8'($urandom);
      pf = 1'($urandom);
      st = ($urandom % 4) != 0;
      drive_rx(d, pf, st, 1'b0);
      check_rx(d, pf, ~st);
      check("rx_hold_data", rx_data, last_rx);
    end

    // TX and RX busy at the same time on independent lines.
    d = 8'($urandom);
    pf = 1'($urandom);
    fork
      send_tx(8'($urandom), 1'b1);
      drive_rx(d, pf, 1'b1, 1'b0);
    join
    check_rx(d, pf, 1'b0);

    // Reset in the middle of data bit 3.
    loopback = 1'b1;
    d = 8'($urandom);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge pclk);
    tx_valid = 1'b0;
    repeat (4 * BAUD + 8) @(negedge pclk);
    check("mid_bit3", tx, d[3]);
    #2 areset = 1'b1;
    #1;
    check("arst_tx", tx, 1'b1);
    check("arst_tx_ready", tx_ready, 1'b1);
    check("arst_rx_data", rx_data, 8'h00);
    check("arst_rx_valid", rx_valid, 1'b0);
    @(negedge pclk);
    areset = 1'b0;
    rxq.delete();
    d = 8'($urandom);
    send_tx(d, 1'b0);
    check_rx(d, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
